operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Register-read stage of the RV32I multicycle pipeline; the reading end of the register file that writeback writes.
//  Accepts decoded source/dest indices from decode and reads rs1/rs2 from the register file.
//  Forwards from memory-stage and writeback bypass buses, and stalls on unresolved producers.
//  Hands operands to execute using the pipeline ready-to-send/ready-to-receive handshake.
// PARAMETERS
//  XLEN     32  data width
//  REG_IDX  5   register index width
//  AMT_REG  32  architectural register count; x0 reads as 0
// PORTS
//  clk  in  1  clock
//  rst  in  1  reset, synchronous, active-high
//  startSig  in  1  pipeline start pulse
//  beforePipReadyToSend  in  1  decode holds a valid instruction
//  nextPipReadyToRcv  in  1  execute can accept
//  curPipReadyToRcv  out  1  this stage accepts decode's instruction this cycle
//  curPipReadyToSend  out  1  operands valid for execute
//  dec_valid  in  1  instruction valid; 0 = bubble
//  dec_rs1, dec_rs2, dec_rd  in  REG_IDX  source and destination indices
//  dec_use_rs1, dec_use_rs2  in  1  source is actually read
//  pend_idx  in  REG_IDX  destination whose value is not yet available (load in flight); 0 = none
//  mem_bp_idx / mem_bp_val  in  REG_IDX / XLEN  memory-stage bypass; idx 0 = none
//  wb_bp_idx / wb_bp_val  in  REG_IDX / XLEN  writeback bypass; idx 0 = none
//  rf_rs1_idx, rf_rs2_idx  out  REG_IDX  register-file read addresses (combinational read)
//  rf_rs1_val, rf_rs2_val  in  XLEN  register-file read data
//  op_valid, op_rd  out  1 / REG_IDX  registered valid and dest to execute
//  op_rs1_val, op_rs2_val  out  XLEN  registered operands
// BEHAVIOUR
//  Reset: state IDLE; all op_* = 0; rf_*_idx = 0; both ready outputs = 0. rst has priority over startSig.
//  States: IDLE, WAIT_BEF, FETCH, SENDING, WAIT_SEND.
//  - IDLE: on startSig, go to FETCH if beforePipReadyToSend (latch dec_*), else to WAIT_BEF.
//  - WAIT_BEF: curPipReadyToRcv=1; on beforePipReadyToSend, latch dec_* and go to FETCH.
//  - FETCH: rf_*_idx = latched indices; resolve each source (below).
//    If no stall, capture op_* at the clock edge and go to SENDING. Otherwise stay in FETCH and re-evaluate every cycle.
//  - SENDING / WAIT_SEND: curPipReadyToSend=1.
//    When nextPipReadyToRcv=1: curPipReadyToRcv=1; go to FETCH (latch dec_*) if beforePipReadyToSend, else to WAIT_BEF.
//    When nextPipReadyToRcv=0: go to WAIT_SEND and hold op_* stable.
//  Latency: accept edge -> at least 1 FETCH cycle -> curPipReadyToSend. Throughput is 1 instruction per 2 cycles.
//  Source resolve, per source, in priority order:
//    use=0 or idx=0 -> value 0, no stall;
//    idx==pend_idx -> stall; this wins over any bypass match;
//    idx==mem_bp_idx -> mem_bp_val (younger producer wins when both buses match);
//    idx==wb_bp_idx -> wb_bp_val;
//    otherwise rf value.
//  dec_valid=0: pass the bubble through; never stall; op_valid=0.
//  Reset mid-operation: state returns to IDLE and the latched instruction is discarded.
// CONFIGURATION
//  OPERAND_FETCH_BYPASS_EN defined: forwarding from both bypass buses as above.
//  Not defined: any match on mem_bp_idx or wb_bp_idx stalls like pend_idx. The value is then read from the register file after writeback commits.
// STRUCTURE
//  Shared package riscv_pipe_pkg holds:
//    pipeline state encodings (IDLE=3'b000, WAIT_BEF=3'b001, SENDING=3'b010, WAIT_SEND=3'b100, FETCH=3'b011);
//    XLEN / REG_IDX constants.
//  Sub-module operand_select, instantiated twice: priority resolve of one source; outputs value and stall.
// TESTING
//  1. rst, then startSig with beforePipReadyToSend=1, rs1=x5 (rf=0x11), rs2=x0, no bypass
//     -> next edge in FETCH; following edge op_rs1_val=0x11, op_rs2_val=0, curPipReadyToSend=1.
//  2. rs1=x7, mem_bp_idx=7 with 0xAA, wb_bp_idx=7 with 0xBB, rf=0xCC
//     -> op_rs1_val=0xAA with BYPASS_EN; without it, stalls while either bus matches, then 0xCC.
//  3. pend_idx=x3, rs2=x3, wb_bp_idx=3; hold pend_idx for 4 cycles
//     -> FETCH held 4 cycles with curPipReadyToSend=0; captures on the cycle pend_idx clears.
//  4. nextPipReadyToRcv=0 for 3 cycles in SENDING -> WAIT_SEND, op_* unchanged, curPipReadyToRcv=0;
//     then release with beforePipReadyToSend=1 -> next instruction latched, state FETCH.
//  5. dec_valid=0 with rs1==pend_idx -> no stall; op_valid=0 after 1 FETCH cycle.
//  6. rst asserted in FETCH, and separately in WAIT_SEND -> IDLE next edge; all outputs 0; startSig required to resume.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared RV32I pipeline constants and stage state encodings
package riscv_pipe_pkg;

    localparam int XLEN    = 32;
    localparam int REG_IDX = 5;
    localparam int AMT_REG = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_WAIT_BEF  = 3'b001,
        ST_SENDING   = 3'b010,
        ST_FETCH     = 3'b011,
        ST_WAIT_SEND = 3'b100
    } pipe_state_e;

endpackage

// File: rtl/operand_select.sv
// rtl/operand_select.sv - priority resolve of one source operand (pending, bypass, register file)
// OPERAND_FETCH_BYPASS_EN: forward from bypass buses; otherwise a bus match stalls until writeback commits.
module operand_select
    import riscv_pipe_pkg::*;
(
    input  logic               use_i,
    input  logic [REG_IDX-1:0] idx_i,
    input  logic [REG_IDX-1:0] pend_idx_i,
    input  logic [REG_IDX-1:0] mem_bp_idx_i,
    input  logic [XLEN-1:0]    mem_bp_val_i,
    input  logic [REG_IDX-1:0] wb_bp_idx_i,
    input  logic [XLEN-1:0]    wb_bp_val_i,
    input  logic [XLEN-1:0]    rf_val_i,
    output logic [XLEN-1:0]    val_o,
    output logic               stall_o
);

    always_comb begin
        val_o   = '0;
        stall_o = 1'b0;
        if (!use_i || idx_i == '0) begin
            val_o = '0;
        end else if (idx_i == pend_idx_i) begin
            stall_o = 1'b1;
`ifdef OPERAND_FETCH_BYPASS_EN
        end else if (idx_i == mem_bp_idx_i) begin
            // memory stage holds the younger producer
            val_o = mem_bp_val_i;
        end else if (idx_i == wb_bp_idx_i) begin
            val_o = wb_bp_val_i;
`else
        end else if (idx_i == mem_bp_idx_i || idx_i == wb_bp_idx_i) begin
            stall_o = 1'b1;
`endif
        end else begin
            val_o = rf_val_i;
        end
    end

`ifndef OPERAND_FETCH_BYPASS_EN
    logic unused_vals;
    assign unused_vals = ^{mem_bp_val_i, wb_bp_val_i};
`endif

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage: latch decode, resolve sources, hand operands to execute
// Bypass forwarding is enabled by OPERAND_FETCH_BYPASS_EN (see operand_select).
module operand_fetch
    import riscv_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               startSig,
    input  logic               beforePipReadyToSend,
    input  logic               nextPipReadyToRcv,
    output logic               curPipReadyToRcv,
    output logic               curPipReadyToSend,
    input  logic               dec_valid,
    input  logic [REG_IDX-1:0] dec_rs1,
    input  logic [REG_IDX-1:0] dec_rs2,
    input  logic [REG_IDX-1:0] dec_rd,
    input  logic               dec_use_rs1,
    input  logic               dec_use_rs2,
    input  logic [REG_IDX-1:0] pend_idx,
    input  logic [REG_IDX-1:0] mem_bp_idx,
    input  logic [XLEN-1:0]    mem_bp_val,
    input  logic [REG_IDX-1:0] wb_bp_idx,
    input  logic [XLEN-1:0]    wb_bp_val,
    output logic [REG_IDX-1:0] rf_rs1_idx,
    output logic [REG_IDX-1:0] rf_rs2_idx,
    input  logic [XLEN-1:0]    rf_rs1_val,
    input  logic [XLEN-1:0]    rf_rs2_val,
    output logic               op_valid,
    output logic [REG_IDX-1:0] op_rd,
    output logic [XLEN-1:0]    op_rs1_val,
    output logic [XLEN-1:0]    op_rs2_val
);

    pipe_state_e state_q, state_d;

    logic               valid_q, use1_q, use2_q;
    logic [REG_IDX-1:0] rs1_q, rs2_q, rd_q;

    logic               op_valid_q;
    logic [REG_IDX-1:0] op_rd_q;
    logic [XLEN-1:0]    op_rs1_q, op_rs2_q;

    logic               accept, capture;
    logic [XLEN-1:0]    src1_val, src2_val;
    logic               src1_stall, src2_stall, stall;

    operand_select u_sel_rs1 (
        .use_i       (use1_q),
        .idx_i       (rs1_q),
        .pend_idx_i  (pend_idx),
        .mem_bp_idx_i(mem_bp_idx),
        .mem_bp_val_i(mem_bp_val),
        .wb_bp_idx_i (wb_bp_idx),
        .wb_bp_val_i (wb_bp_val),
        .rf_val_i    (rf_rs1_val),
        .val_o       (src1_val),
        .stall_o     (src1_stall)
    );

    operand_select u_sel_rs2 (
        .use_i       (use2_q),
        .idx_i       (rs2_q),
        .pend_idx_i  (pend_idx),
        .mem_bp_idx_i(mem_bp_idx),
        .mem_bp_val_i(mem_bp_val),
        .wb_bp_idx_i (wb_bp_idx),
        .wb_bp_val_i (wb_bp_val),
        .rf_val_i    (rf_rs2_val),
        .val_o       (src2_val),
        .stall_o     (src2_stall)
    );

    // a bubble never waits on producers
    assign stall = valid_q && (src1_stall || src2_stall);

    assign rf_rs1_idx = (state_q == ST_FETCH) ? rs1_q : '0;
    assign rf_rs2_idx = (state_q == ST_FETCH) ? rs2_q : '0;

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        capture           = 1'b0;
        curPipReadyToRcv  = 1'b0;
        curPipReadyToSend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startSig) begin
                    if (beforePipReadyToSend) begin
                        accept           = 1'b1;
                        curPipReadyToRcv = 1'b1;
                        state_d          = ST_FETCH;
                    end else begin
                        state_d = ST_WAIT_BEF;
                    end
                end
            end
            ST_WAIT_BEF: begin
                curPipReadyToRcv = 1'b1;
                if (beforePipReadyToSend) begin
                    accept  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!stall) begin
                    capture = 1'b1;
                    state_d = ST_SENDING;
                end
            end
            ST_SENDING, ST_WAIT_SEND: begin
                curPipReadyToSend = 1'b1;
                if (nextPipReadyToRcv) begin
                    curPipReadyToRcv = 1'b1;
                    if (beforePipReadyToSend) begin
                        accept  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WAIT_BEF;
                    end
                end else begin
                    state_d = ST_WAIT_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            use1_q     <= 1'b0;
            use2_q     <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            op_valid_q <= 1'b0;
            op_rd_q    <= '0;
            op_rs1_q   <= '0;
            op_rs2_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                valid_q <= dec_valid;
                use1_q  <= dec_use_rs1;
                use2_q  <= dec_use_rs2;
                rs1_q   <= dec_rs1;
                rs2_q   <= dec_rs2;
                rd_q    <= dec_rd;
            end
            if (capture) begin
                op_valid_q <= valid_q;
                op_rd_q    <= valid_q ? rd_q : '0;
                op_rs1_q   <= valid_q ? src1_val : '0;
                op_rs2_q   <= valid_q ? src2_val : '0;
            end
        end
    end

    assign op_valid   = op_valid_q;
    assign op_rd      = op_rd_q;
    assign op_rs1_val = op_rs1_q;
    assign op_rs2_val = op_rs2_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, startSig, beforePipReadyToSend, nextPipReadyToRcv;
    logic        curPipReadyToRcv, curPipReadyToSend;
    logic        dec_valid, dec_use_rs1, dec_use_rs2;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, pend_idx, mem_bp_idx, wb_bp_idx;
    logic [31:0] mem_bp_val, wb_bp_val;
    logic [4:0]  rf_rs1_idx, rf_rs2_idx;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        op_valid;
    logic [4:0]  op_rd;
    logic [31:0] op_rs1_val, op_rs2_val;
    logic [31:0] rf_mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rf_rs1_val = rf_mem[rf_rs1_idx];
    assign rf_rs2_val = rf_mem[rf_rs2_idx];

    operand_fetch dut (
        .clk(clk), .rst(rst), .startSig(startSig),
        .beforePipReadyToSend(beforePipReadyToSend), .nextPipReadyToRcv(nextPipReadyToRcv),
        .curPipReadyToRcv(curPipReadyToRcv), .curPipReadyToSend(curPipReadyToSend),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .pend_idx(pend_idx),
        .mem_bp_idx(mem_bp_idx), .mem_bp_val(mem_bp_val),
        .wb_bp_idx(wb_bp_idx), .wb_bp_val(wb_bp_val),
        .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .op_valid(op_valid), .op_rd(op_rd), .op_rs1_val(op_rs1_val), .op_rs2_val(op_rs2_val)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic valid);
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_valid = valid;
        dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
    endtask

    // called from WAIT_BEF; leaves the stage in FETCH
    task automatic issue();
        beforePipReadyToSend = 1'b1;
        tick();
        beforePipReadyToSend = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; startSig = 1'b0; beforePipReadyToSend = 1'b0; nextPipReadyToRcv = 1'b0;
        set_dec(5'd0, 5'd0, 5'd0, 1'b0);
        pend_idx = 0; mem_bp_idx = 0; wb_bp_idx = 0; mem_bp_val = 0; wb_bp_val = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        tests++; if ({op_valid, op_rd, op_rs1_val, op_rs2_val} !== 70'd0) begin fails++; $display("FAIL reset_op: got %0h want 0", {op_valid, op_rd, op_rs1_val, op_rs2_val}); end
        tests++; if ({rf_rs1_idx, rf_rs2_idx, curPipReadyToRcv, curPipReadyToSend} !== 12'd0) begin fails++; $display("FAIL reset_ctl: got %0h want 0", {rf_rs1_idx, rf_rs2_idx, curPipReadyToRcv, curPipReadyToSend}); end
    endtask

    task automatic test_basic();
        set_dec(5'd5, 5'd0, 5'd9, 1'b1);
        startSig = 1'b1; beforePipReadyToSend = 1'b1;
        tick();
        startSig = 1'b0; beforePipReadyToSend = 1'b0;
        tests++; if (dut.state_q !== ST_FETCH) begin fails++; $display("FAIL basic_fetch: got %0d want %0d", dut.state_q, ST_FETCH); end
        tests++; if (rf_rs1_idx !== 5'd5) begin fails++; $display("FAIL basic_rfidx: got %0d want 5", rf_rs1_idx); end
        tests++; if (curPipReadyToSend !== 1'b0) begin fails++; $display("FAIL basic_send_early: got %b want 0", curPipReadyToSend); end
        tick();
        tests++; if (op_rs1_val !== 32'h11 || op_rs2_val !== 32'h0) begin fails++; $display("FAIL basic_ops: got %h %h want 11 0", op_rs1_val, op_rs2_val); end
        tests++; if (op_valid !== 1'b1 || op_rd !== 5'd9) begin fails++; $display("FAIL basic_valid_rd: got %b %0d want 1 9", op_valid, op_rd); end
        tests++; if (curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL basic_send: got %b want 1", curPipReadyToSend); end
        nextPipReadyToRcv = 1'b1;
        tick();
        nextPipReadyToRcv = 1'b0;
        tests++; if (dut.state_q !== ST_WAIT_BEF || curPipReadyToRcv !== 1'b1) begin fails++; $display("FAIL basic_waitbef: got %0d/%b want %0d/1", dut.state_q, curPipReadyToRcv, ST_WAIT_BEF); end
    endtask

    task automatic test_bypass();
        set_dec(5'd7, 5'd0, 5'd1, 1'b1);
        mem_bp_idx = 5'd7; mem_bp_val = 32'hAA; wb_bp_idx = 5'd7; wb_bp_val = 32'hBB;
        issue();
        tick();
`ifdef OPERAND_FETCH_BYPASS_EN
        tests++; if (op_rs1_val !== 32'hAA || curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL bypass_mem: got %h/%b want aa/1", op_rs1_val, curPipReadyToSend); end
`else
        tests++; if (dut.state_q !== ST_FETCH || curPipReadyToSend !== 1'b0) begin fails++; $display("FAIL nobyp_both: got %0d/%b want FETCH/0", dut.state_q, curPipReadyToSend); end
        mem_bp_idx = 5'd0;
        tick();
        tests++; if (dut.state_q !== ST_FETCH) begin fails++; $display("FAIL nobyp_wb: got %0d want %0d", dut.state_q, ST_FETCH); end
        wb_bp_idx = 5'd0;
        tick();
        tests++; if (op_rs1_val !== 32'hCC || curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL nobyp_rf: got %h/%b want cc/1", op_rs1_val, curPipReadyToSend); end
`endif
        mem_bp_idx = 0; wb_bp_idx = 0;
        nextPipReadyToRcv = 1'b1;
        tick();
        nextPipReadyToRcv = 1'b0;
    endtask

    task automatic test_pending();
        set_dec(5'd0, 5'd3, 5'd2, 1'b1);
        pend_idx = 5'd3; wb_bp_idx = 5'd3; wb_bp_val = 32'h33;
        issue();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (dut.state_q !== ST_FETCH || curPipReadyToSend !== 1'b0) begin fails++; $display("FAIL pend_hold%0d: got %0d/%b want FETCH/0", i, dut.state_q, curPipReadyToSend); end
        end
        pend_idx = 5'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
        tick();
        tests++; if (op_rs2_val !== 32'h33 || curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL pend_clear: got %h/%b want 33/1", op_rs2_val, curPipReadyToSend); end
`else
        tick();
        tests++; if (dut.state_q !== ST_FETCH) begin fails++; $display("FAIL pend_wbstall: got %0d want %0d", dut.state_q, ST_FETCH); end
        wb_bp_idx = 5'd0;
        tick();
        tests++; if (op_rs2_val !== 32'h44 || curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL pend_clear: got %h/%b want 44/1", op_rs2_val, curPipReadyToSend); end
`endif
        wb_bp_idx = 5'd0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        held = op_rs2_val;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (dut.state_q !== ST_WAIT_SEND || op_rs2_val !== held || op_rd !== 5'd2) begin fails++; $display("FAIL hold%0d: got %0d/%h/%0d want WAIT_SEND/%h/2", i, dut.state_q, op_rs2_val, op_rd, held); end
            tests++; if (curPipReadyToRcv !== 1'b0 || curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL hold_rdy%0d: got %b%b want 01", i, curPipReadyToRcv, curPipReadyToSend); end
        end
        set_dec(5'd5, 5'd0, 5'd4, 1'b1);
        nextPipReadyToRcv = 1'b1; beforePipReadyToSend = 1'b1;
        #1;
        tests++; if (curPipReadyToRcv !== 1'b1) begin fails++; $display("FAIL release_rcv: got %b want 1", curPipReadyToRcv); end
        tick();
        beforePipReadyToSend = 1'b0;
        tests++; if (dut.state_q !== ST_FETCH || rf_rs1_idx !== 5'd5) begin fails++; $display("FAIL release_fetch: got %0d/%0d want FETCH/5", dut.state_q, rf_rs1_idx); end
        tick();
        tests++; if (op_rs1_val !== 32'h11 || op_rd !== 5'd4) begin fails++; $display("FAIL release_ops: got %h/%0d want 11/4", op_rs1_val, op_rd); end
        tick();
        nextPipReadyToRcv = 1'b0;
    endtask

    task automatic test_bubble();
        set_dec(5'd5, 5'd0, 5'd6, 1'b0);
        pend_idx = 5'd5;
        issue();
        tick();
        tests++; if (op_valid !== 1'b0 || curPipReadyToSend !== 1'b1) begin fails++; $display("FAIL bubble: got %b/%b want 0/1", op_valid, curPipReadyToSend); end
        pend_idx = 5'd0;
        nextPipReadyToRcv = 1'b1;
        tick();
        nextPipReadyToRcv = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_dec(5'd9, 5'd0, 5'd8, 1'b1);
        pend_idx = 5'd9;
        issue();
        tests++; if (dut.state_q !== ST_FETCH) begin fails++; $display("FAIL rmid_setup: got %0d want %0d", dut.state_q, ST_FETCH); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (dut.state_q !== ST_IDLE || {op_valid, op_rd, op_rs1_val, op_rs2_val} !== 70'd0) begin fails++; $display("FAIL rmid_fetch: got %0d/%0h want IDLE/0", dut.state_q, {op_valid, op_rd, op_rs1_val, op_rs2_val}); end
        tests++; if ({rf_rs1_idx, rf_rs2_idx, curPipReadyToRcv, curPipReadyToSend} !== 12'd0) begin fails++; $display("FAIL rmid_fetch_ctl: got %0h want 0", {rf_rs1_idx, rf_rs2_idx, curPipReadyToRcv, curPipReadyToSend}); end
        pend_idx = 5'd0;
        beforePipReadyToSend = 1'b1;
        tick();
        tests++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL rmid_nostart: got %0d want %0d", dut.state_q, ST_IDLE); end
        startSig = 1'b1; tick(); startSig = 1'b0; beforePipReadyToSend = 1'b0;
        tick();
        tests++; if (op_rs1_val !== 32'h99 || op_rd !== 5'd8) begin fails++; $display("FAIL rmid_resume: got %h/%0d want 99/8", op_rs1_val, op_rd); end
        tick();
        tests++; if (dut.state_q !== ST_WAIT_SEND) begin fails++; $display("FAIL rmid_ws_setup: got %0d want %0d", dut.state_q, ST_WAIT_SEND); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (dut.state_q !== ST_IDLE || {op_valid, op_rd, op_rs1_val, op_rs2_val} !== 70'd0) begin fails++; $display("FAIL rmid_waitsend: got %0d/%0h want IDLE/0", dut.state_q, {op_valid, op_rd, op_rs1_val, op_rs2_val}); end
        tests++; if ({curPipReadyToRcv, curPipReadyToSend} !== 2'b00) begin fails++; $display("FAIL rmid_ws_rdy: got %b%b want 00", curPipReadyToRcv, curPipReadyToSend); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rf_mem[3] = 32'h44; rf_mem[5] = 32'h11; rf_mem[7] = 32'hCC; rf_mem[9] = 32'h99;
        test_reset();
        test_basic();
        test_bypass();
        test_pending();
        test_back_to_back();
        test_bubble();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
